// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates the CPU and loader ports onto one BRAM port,
// builds RV32 byte-lane enables/store data and extends load data on the response.
module dmem_ctrl #(
    parameter int ADDR_BITS    = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [2:0]           c_funct3,
    input  logic [31:0]          c_addr,
    input  logic [31:0]          c_wdata,
    output logic                 c_gnt,
    output logic                 c_rvalid,
    output logic [31:0]          c_rdata,
    output logic                 c_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [2:0]           d_funct3,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [31:0]          d_rdata,
    output logic                 d_err,
    output logic                 bram_ena,
    output logic [3:0]           bram_wea,
    output logic [ADDR_BITS-1:0] bram_addra,
    output logic [31:0]          bram_dina,
    input  logic [31:0]          bram_douta
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    // Handshake: a requester holds req and its fields until gnt (combinational, same
    // cycle); the single response (rvalid/rdata/err) follows exactly one cycle later.
    logic [2:0]  starve_cnt;
    logic        d_win;
    logic        any_gnt;
    logic        sel_we;
    logic [2:0]  sel_f3;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  off;
    logic        legal;
    logic        unused_addr_bits;

    logic        rsp_valid;
    logic        rsp_owner;
    logic        rsp_we;
    logic [2:0]  rsp_funct3;
    logic [1:0]  rsp_off;
    logic        rsp_err;
    logic [31:0] shifted;
    logic [31:0] rsp_data;

    assign d_win = d_req && ((starve_cnt >= LIMIT) || !c_req);

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            d_gnt = d_win;
            c_gnt = c_req && !d_win;
        end
    end

    assign any_gnt   = c_gnt || d_gnt;
    assign sel_we    = d_gnt ? d_we     : c_we;
    assign sel_f3    = d_gnt ? d_funct3 : c_funct3;
    assign sel_addr  = d_gnt ? d_addr   : c_addr;
    assign sel_wdata = d_gnt ? d_wdata  : c_wdata;
    assign off       = sel_addr[1:0];
    // Bytes above the BRAM range alias onto it.
    assign unused_addr_bits = ^sel_addr[31:ADDR_BITS+2];

    always_comb begin
        case (sel_f3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = !off[0];
            3'b010:         legal = (off == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    always_comb begin
        bram_ena   = 1'b0;
        bram_wea   = 4'b0000;
        bram_addra = '0;
        bram_dina  = 32'h0;
        if (any_gnt && legal) begin
            bram_ena   = 1'b1;
            bram_addra = sel_addr[ADDR_BITS+1:2];
            if (sel_we) begin
                case (sel_f3[1:0])
                    2'b00: begin
                        bram_wea  = 4'b0001 << off;
                        bram_dina = {4{sel_wdata[7:0]}};
                    end
                    2'b01: begin
                        bram_wea  = 4'b0011 << off;
                        bram_dina = {2{sel_wdata[15:0]}};
                    end
                    default: begin
                        bram_wea  = 4'b1111;
                        bram_dina = sel_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (d_gnt) begin
            starve_cnt <= 3'd0;
        end else if (d_req && (starve_cnt != 3'd7)) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_owner  <= 1'b0;
            rsp_we     <= 1'b0;
            rsp_funct3 <= 3'b000;
            rsp_off    <= 2'b00;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            if (any_gnt) begin
                rsp_owner  <= d_gnt;
                rsp_we     <= sel_we;
                rsp_funct3 <= sel_f3;
                rsp_off    <= off;
                rsp_err    <= !legal;
            end
        end
    end

    always_comb begin
        shifted = bram_douta >> {rsp_off, 3'b000};
        case (rsp_funct3)
            3'b000:  rsp_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  rsp_data = {24'h0, shifted[7:0]};
            3'b001:  rsp_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  rsp_data = {16'h0, shifted[15:0]};
            default: rsp_data = shifted;
        endcase
        if (rsp_we || rsp_err) begin
            rsp_data = 32'h0;
        end
    end

    assign c_rvalid = rsp_valid && !rsp_owner;
    assign d_rvalid = rsp_valid && rsp_owner;
    assign c_rdata  = c_rvalid ? rsp_data : 32'h0;
    assign d_rdata  = d_rvalid ? rsp_data : 32'h0;
    assign c_err    = c_rvalid && rsp_err;
    assign d_err    = d_rvalid && rsp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: BRAM model, byte-level reference model checked every cycle,
// and directed sequences with hand-computed expectations.
module tb_dmem_ctrl;

    localparam int AW     = 10;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [2:0]    c_funct3 = 3'b000;
    logic [31:0]   c_addr = 32'h0, c_wdata = 32'h0;
    logic          c_gnt, c_rvalid, c_err;
    logic [31:0]   c_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [2:0]    d_funct3 = 3'b000;
    logic [31:0]   d_addr = 32'h0, d_wdata = 32'h0;
    logic          d_gnt, d_rvalid, d_err;
    logic [31:0]   d_rdata;
    logic          bram_ena;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [31:0]   bram_douta = 32'h0;

    dmem_ctrl #(.ADDR_BITS(AW), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .bram_douta(bram_douta)
    );

    always #5 clk = ~clk;

    // BRAM: 1024 words, byte enables, registered read-first output.
    logic [31:0] bram_mem [1024];
    initial for (int i = 0; i < 1024; i++) bram_mem[i] = 32'h0;
    always @(posedge clk) begin
        if (bram_ena) begin
            bram_douta <= bram_mem[bram_addra];
            for (int l = 0; l < 4; l++)
                if (bram_wea[l]) bram_mem[bram_addra][8*l +: 8] <= bram_dina[8*l +: 8];
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a flat byte memory, a denial count and one pending response.
    logic [7:0]  m_mem [4096];
    initial for (int i = 0; i < 4096; i++) m_mem[i] = 8'h0;
    int          denied = 0, n_denied = 0;
    logic        p_valid = 1'b0, p_owner = 1'b0, p_err = 1'b0;
    logic [31:0] p_rdata = 32'h0;
    logic        n_valid = 1'b0, n_owner = 1'b0, n_err = 1'b0;
    logic [31:0] n_rdata = 32'h0;
    logic        w_en = 1'b0;
    int          w_base = 0, w_n = 0;
    logic [31:0] w_data = 32'h0;

    logic        m_wc, m_wd, s_we, s_ok, s_any;
    logic [2:0]  s_f3;
    logic [31:0] s_addr, s_wdata, s_rep;
    logic [3:0]  s_mask;
    int          s_n;
    logic [7:0]  gnt_log[$];
    int          c_rv_cnt = 0, d_rv_cnt = 0;

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic is_legal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (a % 2) == 0;
            3'b010:         return (a % 4) == 0;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int n = nbytes(f3);
        int base = int'(a[11:0]);
        for (int i = 0; i < n; i++) v = v | (32'(m_mem[base + i]) << (8 * i));
        if (f3 == 3'b000 && v >= 32'h80)   v = v + 32'hFFFFFF00;
        if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_c_gnt", 32'(c_gnt), 32'h0);
            chk("rst_d_gnt", 32'(d_gnt), 32'h0);
            chk("rst_ena", 32'(bram_ena), 32'h0);
            chk("rst_wea", 32'(bram_wea), 32'h0);
            chk("rst_addra", 32'(bram_addra), 32'h0);
            chk("rst_dina", bram_dina, 32'h0);
            chk("rst_c_rvalid", 32'(c_rvalid), 32'h0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
            chk("rst_c_rdata", c_rdata, 32'h0);
            chk("rst_d_rdata", d_rdata, 32'h0);
            chk("rst_c_err", 32'(c_err), 32'h0);
            chk("rst_d_err", 32'(d_err), 32'h0);
            n_valid = 1'b0; w_en = 1'b0; n_denied = 0;
        end else begin
            m_wd = d_req && (denied >= STARVE || !c_req);
            m_wc = c_req && !m_wd;
            chk("c_gnt", 32'(c_gnt), 32'(m_wc));
            chk("d_gnt", 32'(d_gnt), 32'(m_wd));
            if (c_gnt) gnt_log.push_back(8'h43);
            if (d_gnt) gnt_log.push_back(8'h44);
            chk("c_rvalid", 32'(c_rvalid), 32'(p_valid && !p_owner));
            chk("d_rvalid", 32'(d_rvalid), 32'(p_valid && p_owner));
            chk("c_rdata", c_rdata, (p_valid && !p_owner) ? p_rdata : 32'h0);
            chk("d_rdata", d_rdata, (p_valid && p_owner) ? p_rdata : 32'h0);
            chk("c_err", 32'(c_err), 32'(p_valid && !p_owner && p_err));
            chk("d_err", 32'(d_err), 32'(p_valid && p_owner && p_err));
            if (c_rvalid) c_rv_cnt++;
            if (d_rvalid) d_rv_cnt++;

            s_any   = m_wc || m_wd;
            s_we    = m_wd ? d_we : c_we;
            s_f3    = m_wd ? d_funct3 : c_funct3;
            s_addr  = m_wd ? d_addr : c_addr;
            s_wdata = m_wd ? d_wdata : c_wdata;
            s_ok    = is_legal(s_f3, s_addr);
            s_n     = nbytes(s_f3);
            s_mask  = 4'b0000;
            s_rep   = 32'h0;
            for (int i = 0; i < s_n; i++) s_mask[int'(s_addr[1:0]) + i] = 1'b1;
            for (int l = 0; l < 4; l++) s_rep[8*l +: 8] = s_wdata[8*(l % s_n) +: 8];
            if (s_any && s_ok) begin
                chk("bram_ena", 32'(bram_ena), 32'h1);
                chk("bram_addra", 32'(bram_addra), (s_addr % 4096) / 4);
                chk("bram_wea", 32'(bram_wea), s_we ? 32'(s_mask) : 32'h0);
                if (s_we) chk("bram_dina", bram_dina, s_rep);
            end else begin
                chk("bram_ena_off", 32'(bram_ena), 32'h0);
                chk("bram_wea_off", 32'(bram_wea), 32'h0);
                if (!s_any) begin
                    chk("idle_addra", 32'(bram_addra), 32'h0);
                    chk("idle_dina", bram_dina, 32'h0);
                end
            end
            n_valid = s_any;
            n_owner = m_wd;
            n_err   = !s_ok;
            n_rdata = (s_ok && !s_we) ? load_val(s_f3, s_addr) : 32'h0;
            w_en    = s_any && s_ok && s_we;
            w_base  = int'(s_addr[11:0]);
            w_n     = s_n;
            w_data  = s_wdata;
            if (m_wd) n_denied = 0;
            else if (d_req && denied < 7) n_denied = denied + 1;
            else n_denied = denied;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid = 1'b0;
            denied  = 0;
        end else begin
            if (w_en) for (int i = 0; i < w_n; i++) m_mem[w_base + i] = w_data[8*i +: 8];
            p_valid = n_valid; p_owner = n_owner; p_err = n_err; p_rdata = n_rdata;
            denied  = n_denied;
        end
    end

    logic        last_ena;
    logic [3:0]  last_wea;
    logic [31:0] last_addra, last_dina;
    logic [31:0] rd;
    logic        er;

    task automatic op(input bit port, input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err);
        bit g = 0;
        @(posedge clk); #1;
        if (port) begin d_req = 1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd; end
        else begin c_req = 1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd; end
        for (int n = 0; n < 20 && !g; n++) begin
            @(negedge clk);
            g = port ? d_gnt : c_gnt;
            if (g) begin
                last_ena = bram_ena; last_wea = bram_wea;
                last_addra = 32'(bram_addra); last_dina = bram_dina;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("op_gnt", 32'(g), 32'h1);
        @(posedge clk); #1;
        c_req = 0; d_req = 0;
        @(negedge clk);
        chk("op_rvalid", 32'(port ? d_rvalid : c_rvalid), 32'h1);
        rdata = port ? d_rdata : c_rdata;
        err   = port ? d_err : c_err;
    endtask

    function automatic logic [31:0] sdata(input int i);
        return 32'hA5000000 + 32'(i) * 32'h01010101;
    endfunction

    initial begin
        string pat;
        pat = "CCCCDCCCCD";
        repeat (3) @(posedge clk);
        #1 rst = 0;

        op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
        chk("sw_wea", 32'(last_wea), 32'hF);
        chk("sw_addra", last_addra, 32'h4);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err", 32'(er), 32'h0);
        op(0, 0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("lw_rdata", rd, 32'hDEADBEEF);

        op(0, 1, 3'b000, 32'h13, 32'h80, rd, er);
        chk("sb_wea", 32'(last_wea), 32'h8);
        chk("sb_dina", last_dina, 32'h80808080);
        op(0, 0, 3'b000, 32'h13, 32'h0, rd, er);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        op(0, 0, 3'b100, 32'h13, 32'h0, rd, er);
        chk("lbu_rdata", rd, 32'h00000080);
        op(0, 0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("sb_word", rd, 32'h80ADBEEF);

        op(0, 0, 3'b001, 32'h11, 32'h0, rd, er);
        chk("lh_mis_err", 32'(er), 32'h1);
        chk("lh_mis_rdata", rd, 32'h0);
        chk("lh_mis_ena", 32'(last_ena), 32'h0);
        op(0, 1, 3'b011, 32'h10, 32'h12345678, rd, er);
        chk("f3_011_err", 32'(er), 32'h1);
        chk("f3_011_ena", 32'(last_ena), 32'h0);
        op(0, 1, 3'b010, 32'h12, 32'h55555555, rd, er);
        chk("sw_mis_err", 32'(er), 32'h1);
        op(0, 0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("err_unchanged", rd, 32'h80ADBEEF);

        op(1, 1, 3'b001, 32'h16, 32'h1234ABCD, rd, er);
        chk("sh_wea", 32'(last_wea), 32'hC);
        chk("sh_dina", last_dina, 32'hABCDABCD);
        op(1, 0, 3'b001, 32'h16, 32'h0, rd, er);
        chk("lh_rdata", rd, 32'hFFFFABCD);
        op(1, 0, 3'b101, 32'h16, 32'h0, rd, er);
        chk("lhu_rdata", rd, 32'h0000ABCD);
        op(0, 0, 3'b010, 32'h14, 32'h0, rd, er);
        chk("sh_word", rd, 32'hABCD0000);

        op(0, 1, 3'b010, 32'h1010, 32'h11223344, rd, er);
        chk("alias_addra", last_addra, 32'h4);
        op(0, 0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("alias_rdata", rd, 32'h11223344);

        // Both ports requesting continuously.
        @(posedge clk); #1;
        gnt_log.delete(); c_rv_cnt = 0; d_rv_cnt = 0;
        c_req = 1; c_we = 0; c_funct3 = 3'b010; c_addr = 32'h10;
        d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h14;
        repeat (10) @(posedge clk);
        #1 c_req = 0; d_req = 0;
        @(posedge clk); #1;
        chk("arb_len", 32'(gnt_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            chk($sformatf("arb_%0d", i), 32'(gnt_log[i]), 32'(pat[i]));
        chk("arb_c_rv", 32'(c_rv_cnt), 32'd8);
        chk("arb_d_rv", 32'(d_rv_cnt), 32'd2);

        // Loader-only back-to-back stores then loads.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            d_req = 1; d_funct3 = 3'b010;
            d_we = (i < 8);
            d_addr = 32'h100 + 32'(4 * (i % 8));
            d_wdata = sdata(i % 8);
            @(negedge clk);
            chk("stream_gnt", 32'(d_gnt), 32'h1);
            if (i >= 9) chk("stream_rdata", d_rdata, sdata(i - 9));
        end
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_funct3 = 3'b010; c_addr = 32'h10;
        d_addr = 32'h100;
        @(negedge clk);
        chk("stream_last", d_rdata, sdata(7));
        chk("post_stream_cpu", 32'(c_gnt), 32'h1);
        @(posedge clk); #1;
        c_req = 0;
        @(negedge clk);
        chk("post_stream_d", 32'(d_gnt), 32'h1);
        @(posedge clk); #1;
        d_req = 0;

        // Reset in the response cycle of a CPU load.
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_funct3 = 3'b010; c_addr = 32'h10;
        @(negedge clk);
        chk("rst_pre_gnt", 32'(c_gnt), 32'h1);
        @(posedge clk); #1;
        c_req = 0; rst = 1;
        #1;
        chk("rst_async_rvalid", 32'(c_rvalid), 32'h0);
        c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hBAD0BAD0;
        d_req = 1; d_we = 1; d_funct3 = 3'b010; d_addr = 32'h14; d_wdata = 32'h0BAD0BAD;
        repeat (3) @(posedge clk);
        #1 c_req = 0; d_req = 0; rst = 0;
        op(0, 0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("post_rst_lw", rd, 32'h11223344);
        op(1, 0, 3'b010, 32'h14, 32'h0, rd, er);
        chk("post_rst_lw2", rd, 32'hABCD0000);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting between the pipeline MEM stage, a secondary loader/debug master and the single-port 32-bit data BRAM (1024 words, byte write enables, one-cycle registered read). It arbitrates the two requesters onto the one BRAM port and generates RV32 byte-lane enables and store data for SB/SH/SW. It also sign- or zero-extends load data for LB/LH/LW/LBU/LHU and flags misaligned accesses. The starvation guard keeps the CPU from locking out the loader indefinitely.

## Interface
- ADDR_BITS, 10, BRAM word-address width; byte address bits [ADDR_BITS+1:2] select the word.
- STARVE_LIMIT, 4, consecutive denied loader cycles after which the loader wins priority; range 1..7.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU access request, held until c_gnt.
- c_we  in  1  1 = store, 0 = load.
- c_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- c_addr  in  32  byte address.
- c_wdata  in  32  store data, right-aligned.
- c_gnt  out  1  request accepted this cycle.
- c_rvalid  out  1  response valid.
- c_rdata  out  32  extended load data; 0 for stores and errors.
- c_err  out  1  response is misaligned or illegal funct3.
- d_req, d_we, d_funct3, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: loader port, identical meaning.
- bram_ena  out  1  BRAM enable.
- bram_wea  out  4  BRAM byte write enables.
- bram_addra  out  ADDR_BITS  BRAM word address.
- bram_dina  out  32  BRAM write data, lane-replicated.
- bram_douta  in  32  BRAM read data, valid the cycle after bram_ena.

## Operation
- Arbitration, per cycle, combinational:
  - Default winner is the CPU.
  - The loader wins if starve_cnt ≥ STARVE_LIMIT, or if only d_req is high.
  - Exactly one gnt is asserted per cycle, or none.
- starve_cnt is 3 bits, saturating:
  - +1 each cycle d_req && !d_gnt.
  - Cleared on d_gnt.
  - Holds when d_req is low.
- Legality: byte always legal; half requires addr[0]=0; word requires addr[1:0]=00. funct3 011, 110 and 111 are illegal.
- Legal granted access:
  - bram_ena=1 and bram_addra=addr[ADDR_BITS+1:2].
  - Stores drive wea = 0001<<off for SB, 0011<<off for SH (off is 0 or 2), and 1111 for SW.
  - bram_dina replicates the byte or half across all lanes.
- Illegal granted access:
  - gnt still asserts (request consumed).
  - bram_ena=0 and wea=0.
  - The response carries err=1 and rdata=0.
- No grant: bram_ena=0, wea=0, addra=0, dina=0.
- Response register, loaded on any grant: rsp_valid, rsp_owner, rsp_we, rsp_funct3, rsp_off[1:0], rsp_err.
- Response cycle:
  - The owner's rvalid=1.
  - For legal loads, rdata = bram_douta >> (8*off), extended per funct3.
  - For legal stores, rdata=0 and err=0.
  - The other port's rvalid=0.
- Addresses above the BRAM range alias (upper bits are ignored); no error is raised.

## Timing
- Request in cycle N, gnt combinational in N, BRAM access at edge N+1, rvalid and rdata in cycle N+1. Load latency is 1.
- Back-to-back grants every cycle are supported. The response for N overlaps the grant for N+1.
- A store followed by a load to the same word in the next cycle returns the new data. The BRAM write precedes the read of the next access.
- Requester rule: the requester must hold req and its fields stable until gnt. After gnt it may change them the same cycle.
- Simultaneous requests with starve_cnt < LIMIT: CPU granted and counter increments.
- Simultaneous requests with starve_cnt ≥ LIMIT: loader granted and counter clears.
- Reset values:
  - All gnt, rvalid and err outputs are 0; rdata is 0.
  - bram_ena=0, bram_wea=0, addra=0, dina=0.
  - starve_cnt=0 and rsp_valid=0.
- rst asserted mid-operation:
  - Pending response dropped and rvalid deasserts immediately (asynchronous).
  - gnt and bram_ena are forced to 0 while rst is high, so no write can occur during reset.
- First cycle after rst release: arbitration resumes normally.

## Test plan
- SW 0xDEADBEEF at 0x10 (CPU), then LW 0x10 → gnt both cycles, wea=1111, addra=4. Load rvalid one cycle later with rdata=0xDEADBEEF.
- SB 0x80 at 0x13, then LB/LBU 0x13 → wea=1000, dina=0x80808080. LB returns 0xFFFFFF80; LBU returns 0x00000080; other bytes of the word are unchanged.
- LH at 0x11, and funct3=011 → gnt=1, bram_ena=0, rvalid with err=1 and rdata=0; memory is unchanged.
- c_req and d_req held high continuously with STARVE_LIMIT=4 → grant pattern C,C,C,C,D repeating. Each response goes to the correct port with no lost or duplicated rvalid.
- Loader-only stream of 8 back-to-back SW then LW → one access per cycle, data matches, starve_cnt stays 0.
- Assert rst in the cycle after a CPU LW grant → c_rvalid drops immediately and no BRAM enable occurs during reset. After release, a fresh LW returns the stored value.
